// File: rtl/bus_cycle_master.sv
// bus_cycle_master: single-transfer bus-cycle initiator driving the 3-bit
// high-address bus, active-low strobe and write enable through a
// SETUP / STROBE / HOLD sequence with programmable and target-extended wait.
// Optional feature macro: UNMAPPED_CHECK_EN (reject unmapped addresses in IDLE).
module bus_cycle_master #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] req_addr,
  input  logic       req_wr,
  input  logic       ext_wait,
  output logic [2:0] addr_H,
  output logic       strobe_n,
  output logic       wr_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic       r_wr;
  logic [2:0] r_addr_H;
  logic       r_strobe_n;
  logic       r_wr_n;
  logic       r_busy;
  logic       r_done;
  logic       w_accept;

`ifdef UNMAPPED_CHECK_EN
  logic       r_err;
  logic       w_mapped;
  logic       w_reject;

  // Mapped set is 10x and 01x, i.e. the top two address bits differ.
  always_comb begin
    w_mapped = req_addr[2] ^ req_addr[1];
    w_accept = (r_state == S_IDLE) && req && w_mapped;
    w_reject = (r_state == S_IDLE) && req && !w_mapped;
  end

  // One-cycle reject pulse; the FSM stays parked in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_reject;
  end

  assign err = r_err;
`else
  // Every address runs a full bus cycle when the check is compiled out.
  always_comb begin
    w_accept = (r_state == S_IDLE) && req;
  end

  assign err = 1'b0;
`endif

  // Bus-cycle FSM; outputs are registered with the values of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_addr_H   <= '0;
      r_strobe_n <= 1'b1;
      r_wr_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_SETUP;
            r_wr     <= req_wr;
            r_addr_H <= req_addr;
            r_busy   <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state    <= S_STROBE;
          r_cnt      <= 8'(WAIT_CYCLES);
          r_strobe_n <= 1'b0;
          r_wr_n     <= ~r_wr;
        end
        S_STROBE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (!ext_wait) begin
            r_state    <= S_HOLD;
            r_strobe_n <= 1'b1;
            r_wr_n     <= 1'b1;
            r_done     <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_addr_H <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign addr_H   = r_addr_H;
  assign strobe_n = r_strobe_n;
  assign wr_n     = r_wr_n;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_bus_cycle_master.sv
// tb_bus_cycle_master: scoreboard bench for bus_cycle_master. Each transfer
// pushes its expected completion (address, latency) when it is driven; the
// record is popped and compared when done is observed. Bus outputs are also
// compared every cycle against an independent timing model.
module tb_bus_cycle_master;
  localparam int W = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [2:0] req_addr;
  logic       req_wr;
  logic       ext_wait;
  logic [2:0] addr_H;
  logic       strobe_n;
  logic       wr_n;
  logic       busy;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] addr;
    int         lat;
  } txn_t;
  txn_t sb[$];

  bus_cycle_master #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wr(req_wr),
    .ext_wait(ext_wait), .addr_H(addr_H), .strobe_n(strobe_n), .wr_n(wr_n),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {addr_H, strobe_n, wr_n, busy, done, err};
  endfunction

  // req must already be driven for edge 0; samples cycles 1..H+1 at negedge.
  // keep=1 leaves req high and switches req_addr to alt during cycle 2.
  task automatic run_txn(input logic [2:0] a, input logic w, input int e,
                         input bit keep, input logic [2:0] alt);
    int   h;
    txn_t t;
    txn_t got_t;
    logic sl;
    logic [7:0] expv;
    h = 3 + W + e;
    t.addr = a;
    t.lat  = h;
    sb.push_back(t);
    for (int n = 1; n <= h + 1; n++) begin
      @(negedge clk);
      sl   = (n >= 2) && (n <= h - 1);
      expv = {(n <= h) ? a : 3'b000, ~sl, ~(sl & w), (n <= h), (n == h), 1'b0};
      check($sformatf("cyc%0d_a%0d", n, a), outs(), expv);
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", done, 0);
        end else begin
          got_t = sb.pop_front();
          check("done_lat", n, got_t.lat);
          check("done_addr", addr_H, got_t.addr);
        end
      end
      if (n == 1 && !keep) begin
        req      = 1'b0;
        req_addr = ~a;
        req_wr   = ~w;
      end
      if (n == 2 && keep) req_addr = alt;
      ext_wait = (n >= 2 + W) && (n < 2 + W + e);
    end
    if (sb.size() != 0) begin
      check("done_missing", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic [2:0] a, input logic w);
    req      = 1'b1;
    req_addr = a;
    req_wr   = w;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_addr = '0; req_wr = 1'b0; ext_wait = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), {3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", outs(), {3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    // Plain read, write, and read with target wait extension.
    issue(3'b100, 1'b0); run_txn(3'b100, 1'b0, 0, 1'b0, 3'b000);
    @(negedge clk); issue(3'b011, 1'b1); run_txn(3'b011, 1'b1, 0, 1'b0, 3'b000);
    @(negedge clk); issue(3'b101, 1'b0); run_txn(3'b101, 1'b0, 3, 1'b0, 3'b000);
    @(negedge clk); issue(3'b010, 1'b1); run_txn(3'b010, 1'b1, 1, 1'b0, 3'b000);

    // Unmapped address.
    @(negedge clk); issue(3'b110, 1'b1);
`ifdef UNMAPPED_CHECK_EN
    @(negedge clk);
    check("unmapped_err", outs(), {3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    req = 1'b0;
    for (int n = 2; n <= 6; n++) begin
      @(negedge clk);
      check($sformatf("unmapped_idle%0d", n), outs(), {3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    end
`else
    run_txn(3'b110, 1'b1, 0, 1'b0, 3'b000);
`endif

    // Asynchronous reset mid-STROBE aborts without a done pulse.
    @(negedge clk); issue(3'b101, 1'b1);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_strobe", {strobe_n, wr_n, busy}, 3'b001);
    #1 rst = 1'b1;
    #1 check("async_rst", outs(), {3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d", n), {busy, done}, 2'b00);
    end
    issue(3'b100, 1'b1); run_txn(3'b100, 1'b1, 0, 1'b0, 3'b000);

    // req held high: address change mid-cycle only affects the next transfer.
    @(negedge clk); issue(3'b101, 1'b0);
    run_txn(3'b101, 1'b0, 0, 1'b1, 3'b010);
    run_txn(3'b010, 1'b0, 0, 1'b0, 3'b000);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_cycle_master.md
# bus_cycle_master

Bus-cycle initiator that drives the 3-bit high-address bus feeding the chip-select decode logic, plus the active-low strobe and write-enable lines. It accepts single read/write requests from the local controller and runs a fixed SETUP / STROBE / HOLD bus cycle with a programmable wait count and target-driven wait extension. It then reports completion, or rejects unmapped addresses when that check is compiled in.

## Interface
Parameters:
- WAIT_CYCLES, 2, extra STROBE cycles beyond the first (0..255); minimum strobe width is WAIT_CYCLES+1 cycles

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  1  request valid; accepted only when the FSM is in IDLE
- req_addr  in  3  target high address; captured on accept
- req_wr  in  1  1 = write, 0 = read; captured on accept
- ext_wait  in  1  target wait request; sampled in the last STROBE cycle
- addr_H  out  3  high-address bus to the chip-select decoder
- strobe_n  out  1  active-low bus strobe
- wr_n  out  1  active-low write enable; low only while strobe_n is low and the request is a write
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle reject pulse for unmapped addresses (macro only)

## Operation
- All outputs are registered.
- Reset values: addr_H = 3'b000 (park address, decodes to no chip selected), strobe_n = 1, wr_n = 1, busy = 0, done = 0, err = 0, state = IDLE, wait counter = 0.
- Mapped addresses: 3'b100, 3'b101, 3'b010, 3'b011. Unmapped addresses: 3'b000, 3'b001, 3'b110, 3'b111.
- IDLE:
  - Outputs sit at their park values.
  - req = 1 at a clock edge captures req_addr and req_wr, then moves to SETUP.
  - Rejected requests are handled as described under Configuration.
- SETUP, 1 cycle:
  - addr_H = captured address; strobe_n = 1; busy = 1.
  - Loads the wait counter with WAIT_CYCLES.
- STROBE:
  - strobe_n = 0; wr_n = !captured_wr; addr_H held.
  - Counter decrements each cycle.
  - When the counter is 0 and ext_wait = 0, moves to HOLD.
  - When the counter is 0 and ext_wait = 1, stays in STROBE for another cycle; this repeats with no limit.
- HOLD, 1 cycle:
  - strobe_n = 1; wr_n = 1; addr_H held; done = 1.
  - Then moves to IDLE, where addr_H returns to 3'b000 and busy = 0.
- req, req_addr and req_wr are ignored while busy; changes to them never affect a cycle in progress.
- Back-to-back transfers: HOLD always returns to IDLE, so consecutive cycles are separated by at least one IDLE cycle.
- Reset asserted mid-cycle forces all outputs and state to their reset values immediately, without waiting for a clock edge. The aborted transfer produces no done pulse.

## Timing
Let edge 0 be the edge that accepts the request; cycle n is the period after edge n.
- Cycle 1: SETUP.
- Cycles 2 .. 2+WAIT_CYCLES: STROBE, plus one extra cycle for each edge at which ext_wait = 1 in the last STROBE cycle.
- Next cycle: HOLD, with done = 1.
- Next cycle: IDLE, busy = 0; earliest point at which a new req can be accepted.
- Latency from accept to done, with no extension: WAIT_CYCLES+3 cycles.
- addr_H is stable from SETUP through HOLD, so it is valid one cycle before strobe_n falls and one cycle after strobe_n rises.
- wr_n changes in the same cycles as strobe_n.

## Configuration
- Macro UNMAPPED_CHECK_EN.
- Defined: a request to an unmapped address is consumed in IDLE.
  - err = 1 for exactly the next cycle.
  - The FSM stays in IDLE; busy, strobe_n and addr_H do not change.
  - No done pulse.
- Undefined: the err port is tied to 0, and every address runs a normal bus cycle. An unmapped address drives addr_H with strobe_n low, so no chip is selected.

## Test plan
- Read, WAIT_CYCLES = 2, req_addr = 3'b100, req_wr = 0, ext_wait = 0, accepted at edge 0 -> addr_H = 100 in cycles 1–5; strobe_n = 0 in cycles 2–4; wr_n stays 1; done = 1 in cycle 5 only; busy = 1 in cycles 1–5; addr_H = 000 in cycle 6.
- Write to 3'b011 with the same timing -> wr_n = 0 exactly in cycles 2–4, coincident with strobe_n.
- Read to 3'b101 with ext_wait = 1 for the three edges starting at cycle 4 -> strobe_n = 0 in cycles 2–7; done in cycle 8.
- req_addr = 3'b110: with UNMAPPED_CHECK_EN -> err = 1 in cycle 1, busy stays 0, strobe_n stays 1; without the macro -> normal cycle with addr_H = 110 and done in cycle 5.
- rst pulsed in cycle 3, mid-STROBE -> addr_H = 000, strobe_n = 1, wr_n = 1, busy = 0 without waiting for a clock edge; no done pulse; a request after release completes normally.
- req held high with req_addr = 3'b101, switched to 3'b010 during cycle 2 -> first cycle uses 101; the second request is accepted at edge 6 (cycle 6 in IDLE) using 010, and its done is in cycle 11.
